// File: rtl/umireg_host.sv
`default_nettype none
// ============================================================================
//  Module      : umireg_host
//  Description : Host-side request sequencer for a UMI register device.
//                Takes one register command at a time from a local
//                controller, issues it as a single-beat UMI read, write or
//                posted write, waits for the matching response (bounded by
//                a timeout) and reports data / error code / timeout back.
//
//  Ports
//    clk_i, reset_i          clock, synchronous active-high reset
//    host_valid_i/ready_o    command handshake from the local controller
//    host_write_i            1 = write, 0 = read
//    host_posted_i           with host_write_i: posted write, no response
//    host_addr_i/wdata_i     register address / write data
//    host_done_o             one-cycle completion pulse
//    host_rdata_o            read data (held until the next completion)
//    host_err_o              response cmd[26:25] (held until next completion)
//    host_timeout_o          completion was a timeout (cleared on accept)
//    udev_req_*              UMI request channel towards the device
//    udev_resp_*             UMI response channel from the device
//
//  Revision    : 1.0  initial release
// ============================================================================
module umireg_host #(
    parameter int            RW       = 32,
    parameter int            CW       = 32,
    parameter int            AW       = 64,
    parameter int            DW       = 64,
    parameter logic [AW-1:0] HOSTADDR = '0,
    parameter logic [4:0]    HOSTID   = 5'd0,
    parameter int            TOW      = 16,
    parameter int            TIMEOUT  = 1000
) (
    input  logic          clk_i,
    input  logic          reset_i,

    // local controller command port
    input  logic          host_valid_i,
    input  logic          host_write_i,
    input  logic          host_posted_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [RW-1:0] host_wdata_i,
    output logic          host_ready_o,
    output logic          host_done_o,
    output logic [RW-1:0] host_rdata_o,
    output logic [1:0]    host_err_o,
    output logic          host_timeout_o,

    // UMI request channel
    output logic          udev_req_valid_o,
    output logic [CW-1:0] udev_req_cmd_o,
    output logic [AW-1:0] udev_req_dstaddr_o,
    output logic [AW-1:0] udev_req_srcaddr_o,
    output logic [DW-1:0] udev_req_data_o,
    input  logic          udev_req_ready_i,

    // UMI response channel
    input  logic          udev_resp_valid_i,
    input  logic [CW-1:0] udev_resp_cmd_i,
    input  logic [AW-1:0] udev_resp_dstaddr_i,
    input  logic [AW-1:0] udev_resp_srcaddr_i,
    input  logic [DW-1:0] udev_resp_data_i,
    output logic          udev_resp_ready_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [4:0] c_OP_READ       = 5'h01;
    localparam logic [4:0] c_OP_RESP_READ  = 5'h02;
    localparam logic [4:0] c_OP_WRITE      = 5'h03;
    localparam logic [4:0] c_OP_RESP_WRITE = 5'h04;
    localparam logic [4:0] c_OP_POSTED     = 5'h05;

    // UMI size field: log2 of the transfer size in bytes
    localparam logic [2:0] c_SIZE = 3'($clog2(RW / 8));

    // The counter starts at 0 on the first WAIT cycle and the transaction is
    // abandoned in the cycle where its next value would reach TIMEOUT-1, so
    // host_done (timeout) appears TIMEOUT cycles after the request handshake.
    // One extra bit keeps the increment/compare free of wrap-around.
    localparam logic [TOW:0] c_TO_LAST = (TOW + 1)'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]    state_q,     state_d;
    logic          req_valid_q, req_valid_d;
    logic [CW-1:0] cmd_q,       cmd_d;
    logic [AW-1:0] dstaddr_q,   dstaddr_d;
    logic [AW-1:0] srcaddr_q,   srcaddr_d;
    logic [DW-1:0] data_q,      data_d;
    logic          write_q,     write_d;
    logic          posted_q,    posted_d;
    logic [TOW-1:0] cnt_q,      cnt_d;
    logic [RW-1:0] rdata_q,     rdata_d;
    logic [1:0]    err_q,       err_d;
    logic          timeout_q,   timeout_d;

    logic          w_req_hs;
    logic [4:0]    w_exp_op;
    logic          w_resp_match;
    logic [TOW:0]  w_cnt_inc;
    logic          w_expire;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    assign w_req_hs  = req_valid_q & udev_req_ready_i;
    assign w_exp_op  = write_q ? c_OP_RESP_WRITE : c_OP_RESP_READ;

    // A response only counts if it is the expected kind and addressed to us;
    // anything else is accepted (ready is always high) and silently dropped.
    assign w_resp_match = udev_resp_valid_i
                        & (udev_resp_cmd_i[4:0] == w_exp_op)
                        & (udev_resp_dstaddr_i == HOSTADDR);

    assign w_cnt_inc = {1'b0, cnt_q} + {{TOW{1'b0}}, 1'b1};
    assign w_expire  = (w_cnt_inc >= c_TO_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        cmd_d       = cmd_q;
        dstaddr_d   = dstaddr_q;
        srcaddr_d   = srcaddr_q;
        data_d      = data_q;
        write_d     = write_q;
        posted_d    = posted_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        timeout_d   = timeout_q;

        case (state_q)
            c_ST_IDLE: begin
                if (host_valid_i) begin
                    state_d     = c_ST_REQ;
                    req_valid_d = 1'b1;

                    cmd_d        = '0;
                    cmd_d[4:0]   = host_write_i
                                 ? (host_posted_i ? c_OP_POSTED : c_OP_WRITE)
                                 : c_OP_READ;
                    cmd_d[7:5]   = c_SIZE;
                    cmd_d[22]    = 1'b1;          // single beat: end of message
                    cmd_d[31:27] = HOSTID;

                    dstaddr_d        = host_addr_i;
                    srcaddr_d        = HOSTADDR;
                    data_d           = '0;
                    data_d[RW-1:0]   = host_wdata_i;

                    write_d   = host_write_i;
                    posted_d  = host_write_i & host_posted_i;
                    timeout_d = 1'b0;
                end
            end

            c_ST_REQ: begin
                // Request fields stay frozen until the device takes them;
                // there is deliberately no timeout on the request side.
                if (w_req_hs) begin
                    req_valid_d = 1'b0;
                    if (posted_q) begin
                        state_d = c_ST_DONE;
                        err_d   = 2'b00;
                    end else begin
                        cnt_d   = '0;
                        state_d = c_ST_WAIT;
                    end
                end
            end

            c_ST_WAIT: begin
                // A match on the expiry cycle still completes normally.
                if (w_resp_match) begin
                    err_d = udev_resp_cmd_i[26:25];
                    if (!write_q) begin
                        rdata_d = udev_resp_data_i[RW-1:0];
                    end
                    state_d = c_ST_DONE;
                end else if (w_expire) begin
                    timeout_d = 1'b1;
                    err_d     = 2'b00;
                    state_d   = c_ST_DONE;
                end else begin
                    cnt_d = w_cnt_inc[TOW-1:0];
                end
            end

            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= c_ST_IDLE;
            req_valid_q <= 1'b0;
            cmd_q       <= '0;
            dstaddr_q   <= '0;
            srcaddr_q   <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            posted_q    <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 2'b00;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            cmd_q       <= cmd_d;
            dstaddr_q   <= dstaddr_d;
            srcaddr_q   <= srcaddr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            posted_q    <= posted_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign host_ready_o   = (state_q == c_ST_IDLE);
    assign host_done_o    = (state_q == c_ST_DONE);
    assign host_rdata_o   = rdata_q;
    assign host_err_o     = err_q;
    assign host_timeout_o = timeout_q;

    assign udev_req_valid_o   = req_valid_q;
    assign udev_req_cmd_o     = cmd_q;
    assign udev_req_dstaddr_o = dstaddr_q;
    assign udev_req_srcaddr_o = srcaddr_q;
    assign udev_req_data_o    = data_q;

    // Responses are always drained: outside WAIT (e.g. a reply arriving after
    // a timeout) they are simply discarded so the device never stalls.
    assign udev_resp_ready_o = 1'b1;

    // Response fields that carry no information for this host.
    logic w_unused;
    assign w_unused = ^{udev_resp_srcaddr_i, udev_resp_cmd_i, udev_resp_data_i};

endmodule
`default_nettype wire
